// File: rtl/shift_pkg.sv
// Shared opcode encoding and helpers for the pipelined shift unit.
package shift_pkg;

    localparam int SHIFT_OP_W = 3;

    typedef enum logic [SHIFT_OP_W-1:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    function automatic logic shift_is_rotate(input shift_op_e op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered 2^K shift step of the barrel shifter; holds its state while i_hold is set.
module shift_stage
    import shift_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_hold,
    input  logic                  i_valid,
    input  logic [SHIFT_OP_W-1:0] i_op,
    input  logic                  i_sel,
    input  logic                  i_sign,
    input  logic [N-1:0]          i_data,
    output logic                  o_valid,
    output logic [N-1:0]          o_data
);

    localparam int S = 1 << K;

    logic [N-1:0] w_shift;
    logic         r_valid;
    logic [N-1:0] r_data;

    always_comb begin
        w_shift = i_data;
        if (i_sel) begin
            case (shift_op_e'(i_op))
                OP_SLL:  w_shift = {i_data[N-S-1:0], {S{1'b0}}};
                OP_SRL:  w_shift = {{S{1'b0}}, i_data[N-1:S]};
                // Fill comes from the sign captured at input, not from this stage's data
                OP_SRA:  w_shift = {{S{i_sign}}, i_data[N-1:S]};
                OP_ROL:  w_shift = {i_data[N-S-1:0], i_data[N-1:N-S]};
                OP_ROR:  w_shift = {i_data[S-1:0], i_data[N-1:S]};
                default: w_shift = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_data  <= w_shift;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/shift_unit_pipelined.sv
// Pipelined SLL/SRL/SRA/ROL/ROR barrel shifter, log2(N) stages, valid/ready with full backpressure.
// Define SHIFT_UNIT_FLAGS_EN to add the out_zero/out_carry flag outputs.
module shift_unit_pipelined
    import shift_pkg::*;
#(
    parameter int N       = 8,
    parameter int SHAMT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SHIFT_OP_W-1:0] in_op,
    input  logic [N-1:0]          in_a,
    input  logic [SHAMT_W-1:0]    in_shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_data
`ifdef SHIFT_UNIT_FLAGS_EN
    ,
    output logic                  out_zero,
    output logic                  out_carry
`endif
);

    localparam int L = $clog2(N);

    logic                 w_adv;
    logic                 w_oor;
    logic [N-1:0]         w_n_data;
    logic [L-1:0]         w_n_amt;
    logic                 w_n_sign;
    logic [L:0]           w_valid;
    logic [L:0][N-1:0]    w_data;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_oor    = |in_shamt[SHAMT_W-1:L];

    // Out-of-range amounts and illegal ops are resolved here so stages only see 0..N-1
    always_comb begin
        w_n_data = in_a;
        w_n_amt  = in_shamt[L-1:0];
        w_n_sign = in_a[N-1];
        case (shift_op_e'(in_op))
            OP_SLL, OP_SRL: if (w_oor) begin
                w_n_data = '0;
                w_n_amt  = '0;
            end
            OP_SRA: if (w_oor) begin
                w_n_data = {N{in_a[N-1]}};
                w_n_amt  = '0;
            end
            OP_ROL, OP_ROR: ;
            default: begin
                w_n_data = '0;
                w_n_amt  = '0;
            end
        endcase
    end

    assign w_valid[0] = in_valid;
    assign w_data[0]  = w_n_data;

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic [SHIFT_OP_W-1:0] w_op;
        logic                  w_sign;
        logic [L-1:k]          w_amt;

        if (k == 0) begin : g_head
            assign w_op   = in_op;
            assign w_sign = w_n_sign;
            assign w_amt  = w_n_amt;
        end else begin : g_ctl
            // Amount bits already consumed upstream are dropped, so each stage keeps only [L-1:k]
            logic [SHIFT_OP_W-1:0] r_op;
            logic                  r_sign;
            logic [L-1:k]          r_amt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_op   <= '0;
                    r_sign <= 1'b0;
                    r_amt  <= '0;
                end else if (w_adv) begin
                    r_op   <= g_stage[k-1].w_op;
                    r_sign <= g_stage[k-1].w_sign;
                    r_amt  <= g_stage[k-1].w_amt[L-1:k];
                end
            end
            assign w_op   = r_op;
            assign w_sign = r_sign;
            assign w_amt  = r_amt;
        end

        shift_stage #(.N(N), .K(k)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_hold  (!w_adv),
            .i_valid (w_valid[k]),
            .i_op    (w_op),
            .i_sel   (w_amt[k]),
            .i_sign  (w_sign),
            .i_data  (w_data[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    assign out_valid = w_valid[L];
    assign out_data  = w_data[L];

`ifdef SHIFT_UNIT_FLAGS_EN
    logic [L-1:0] w_lo;
    logic [L-1:0] w_idx_dn;
    logic [L-1:0] w_idx_up;
    logic         w_n_carry;
    logic [L-1:0] r_carry;

    assign w_lo     = in_shamt[L-1:0];
    assign w_idx_dn = w_lo - L'(1);
    assign w_idx_up = L'(0) - w_lo;

    // Last bit shifted out; for rotates this is the bit that lands at the wrap-around end
    always_comb begin
        w_n_carry = 1'b0;
        if (in_shamt != '0) begin
            case (shift_op_e'(in_op))
                OP_SLL:  w_n_carry = !w_oor && in_a[w_idx_up];
                OP_SRL:  w_n_carry = !w_oor && in_a[w_idx_dn];
                OP_SRA:  w_n_carry = w_oor ? in_a[N-1] : in_a[w_idx_dn];
                OP_ROL:  w_n_carry = in_a[w_idx_up];
                OP_ROR:  w_n_carry = in_a[w_idx_dn];
                default: w_n_carry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        r_carry <= '0;
        else if (w_adv) r_carry <= {r_carry[L-2:0], w_n_carry};
    end

    assign out_carry = r_carry[L-1];
    assign out_zero  = out_valid && (out_data == '0);
`endif

    a_legal_op: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready) |-> (in_op <= SHIFT_OP_W'(OP_ROR)));

endmodule

// File: tb/tb_shift_unit_pipelined.sv
// Randomized and directed bench for shift_unit_pipelined against an arithmetic reference model.
module tb_shift_unit_pipelined;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_shamt, out_data;
`ifdef SHIFT_UNIT_FLAGS_EN
    logic       out_zero, out_carry;
`endif

    always #5 clk = ~clk;

    shift_unit_pipelined #(.N(8), .SHAMT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFT_UNIT_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       c;
        int         stamp;
    } exp_t;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    bit         chk_lat = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_shift(input int op, input int a, input int sh);
        int r, sa;
        r  = sh % 8;
        sa = (a >= 128) ? a - 256 : a;
        case (op)
            0: return (sh >= 8) ? 8'd0 : 8'((a << sh) & 255);
            1: return (sh >= 8) ? 8'd0 : 8'(a >> sh);
            2: return (sh >= 8) ? ((sa < 0) ? 8'hFF : 8'h00) : 8'(sa >>> sh);
            3: return 8'(((a << r) | (a >> (8 - r))) & 255);
            4: return 8'(((a >> r) | (a << (8 - r))) & 255);
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic ref_carry(input int op, input int a, input int sh);
        logic [7:0] res;
        res = ref_shift(op, a, sh);
        if (sh == 0) return 1'b0;
        case (op)
            0: return (sh >= 8) ? 1'b0 : 1'((a >> (8 - sh)) & 1);
            1: return (sh >= 8) ? 1'b0 : 1'((a >> (sh - 1)) & 1);
            2: return (sh >= 8) ? 1'((a >> 7) & 1) : 1'((a >> (sh - 1)) & 1);
            3: return res[0];
            4: return res[7];
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input bit v, input int op, input int a, input int sh, input bit ordy,
                        input bit use_exp = 1'b0, input logic [7:0] exp = 8'h00);
        exp_t e;
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
        end
        in_valid  = v;
        in_op     = 3'(op);
        in_a      = 8'(a);
        in_shamt  = 8'(sh);
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("data", 32'(out_data), 32'(e.d));
`ifdef SHIFT_UNIT_FLAGS_EN
                check("carry", 32'(out_carry), 32'(e.c));
                check("zero", 32'(out_zero), 32'(e.d == 8'h00));
`endif
                if (chk_lat) check("latency", 32'(cyc - e.stamp), 32'd3);
            end
        end
        if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
        if (v && in_ready) begin
            e.d     = use_exp ? exp : ref_shift(op, a, sh);
            e.c     = ref_carry(op, a, sh);
            e.stamp = cyc;
            q.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 0, 0, 0, 1'b1);
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_ops [5];
        exp_ops = '{8'hA0, 8'h16, 8'hF6, 8'hA5, 8'h96};
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_shamt = '0; out_ready = 1'b1;

        repeat (3) step(1'b0, 0, 0, 0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);

        // back-to-back stream of every op, latency checked
        chk_lat = 1'b1;
        for (int op = 0; op < 5; op++) step(1'b1, op, 'hB4, 3, 1'b1, 1'b1, exp_ops[op]);
        drain();
        chk_lat = 1'b0;

        // range handling
        step(1'b1, 2, 'h81, 200, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1, 'h81, 8,   1'b1, 1'b1, 8'h00);
        step(1'b1, 4, 'h81, 9,   1'b1, 1'b1, 8'hC0);
        for (int op = 0; op < 5; op++) step(1'b1, op, 'h81, 0, 1'b1, 1'b1, 8'h81);
        drain();

`ifdef SHIFT_UNIT_FLAGS_EN
        step(1'b1, 0, 'h80, 1, 1'b1, 1'b1, 8'h00);
        step(1'b1, 1, 'h01, 0, 1'b1, 1'b1, 8'h01);
        drain();
`endif

        // backpressure: fill, stall 5 cycles while offering input, then release
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, 9), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, 9), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, 9), 1'b1);
        drain();

        // randomized traffic with random stalls and bubbles
        for (int i = 0; i < 400; i++) begin
            int sh;
            sh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 255), sh,
                 $urandom_range(0, 9) < 7);
        end
        drain();

        // reset with three results in flight
        for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, 9), 1'b0);
        rst = 1'b1;
        prev_stall = 1'b0;
        q.delete();
        step(1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 0, 0, 1'b1);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        step(1'b1, 3, 'h3C, 2, 1'b1, 1'b1, 8'hF0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
